// File: rtl/lfsr_ctrl.sv
// Sequencing controller for an attached free-running lfsr: seeds it, then either
// streams a fixed number of words (GEN) or measures the sequence period (PERIOD).
//
// state | meaning
// IDLE  | waiting for start; job registers hold last result
// LOAD  | one cycle, lfsr_load_seed asserted with seed_q
// RUN   | GEN: emit lfsr words; PERIOD: count until seed reappears
// DONE  | one cycle, done pulse, then back to IDLE
module lfsr_ctrl #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] seed,
    input  logic [W-1:0] num_words,
    input  logic         abort,
    input  logic [N-1:0] lfsr_data,
    output logic         lfsr_load_seed,
    output logic [N-1:0] lfsr_seed_data,
    output logic         busy,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         done,
    output logic         err,
    output logic [N:0]   period
);

    localparam int CW = (N + 1 > W) ? N + 1 : W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] CNT_TMO = CW'(2 ** N);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  seed_q;
    logic          mode_q;
    logic [W-1:0]  nw_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [N:0]    period_q;
    logic          busy_q, done_q, load_q;

    logic gen_last, per_match, per_timeout, run_end;

    assign gen_last    = !mode_q && (cnt_q == (CW'(nw_q) - CW'(1)));
    assign per_match   = mode_q && (cnt_q != '0) && (lfsr_data == seed_q);
    assign per_timeout = mode_q && !per_match && (cnt_q == CNT_TMO);
    assign run_end     = gen_last || per_match || per_timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (seed == '0)
                        state_d = DONE;
                    else if (!mode && (num_words == '0))
                        state_d = DONE;
                    else
                        state_d = LOAD;
                end
            end
            LOAD:    state_d = abort ? IDLE : RUN;
            RUN: begin
                // abort takes priority over a terminating RUN cycle
                if (abort)
                    state_d = IDLE;
                else if (run_end)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            mode_q   <= 1'b0;
            nw_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            period_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            load_q  <= (state_d == LOAD);
            if (state_q == IDLE && start) begin
                seed_q   <= seed;
                mode_q   <= mode;
                nw_q     <= num_words;
                cnt_q    <= '0;
                err_q    <= (seed == '0);
                period_q <= '0;
            end else if (state_q == RUN && !abort) begin
                cnt_q <= cnt_q + CW'(1);
                if (per_match) begin
                    period_q <= cnt_q[N:0];
                end else if (per_timeout) begin
                    err_q    <= 1'b1;
                    period_q <= '0;
                end
            end
        end
    end

    assign lfsr_load_seed = load_q;
    assign lfsr_seed_data = seed_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign period         = period_q;
    assign out_valid      = (state_q == RUN) && !mode_q;
    assign out_data       = out_valid ? lfsr_data : '0;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Scoreboard bench for lfsr_ctrl driving a behavioural 4-bit lfsr (taps 1100).
// Expected words/done events are queued with their cycle; a monitor pops and compares.
module tb_lfsr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] seed = '0;
    logic [7:0] num_words = '0;
    logic       abort = 1'b0;
    logic [3:0] lfsr_data;
    logic       lfsr_load_seed;
    logic [3:0] lfsr_seed_data;
    logic       busy, out_valid, done, err;
    logic [3:0] out_data;
    logic [4:0] period;

    logic [3:0] lq;
    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int load_cnt = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] data;
        logic       err;
        logic [4:0] period;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    lfsr_ctrl #(.N(4), .W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .num_words(num_words), .abort(abort), .lfsr_data(lfsr_data),
        .lfsr_load_seed(lfsr_load_seed), .lfsr_seed_data(lfsr_seed_data),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .done(done),
        .err(err), .period(period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // x^4 + x^3 + 1, shift left, feedback into bit 0
    always @(posedge clk or negedge reset) begin
        if (!reset)
            lq <= '0;
        else if (lfsr_load_seed)
            lq <= lfsr_seed_data;
        else
            lq <= {lq[2:0], lq[3] ^ lq[2]};
    end

    assign lfsr_data = force_en ? force_val : lq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_word(input logic [3:0] d, input int c);
        ev_t e;
        e.is_done = 1'b0; e.data = d; e.err = 1'b0; e.period = '0; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input logic e_err, input logic [4:0] p, input int c);
        ev_t e;
        e.is_done = 1'b1; e.data = '0; e.err = e_err; e.period = p; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (lfsr_load_seed) load_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %h at cycle %0d, expected none", out_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_kind", 32'(mon_e.is_done), 32'd0);
                    chk("word_data", 32'(out_data), 32'(mon_e.data));
                    chk("word_cycle", cyc, mon_e.cyc);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_kind", 32'(mon_e.is_done), 32'd1);
                    chk("done_err", 32'(err), 32'(mon_e.err));
                    chk("done_period", 32'(period), 32'(mon_e.period));
                    chk("done_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    // call at a negedge; start is sampled on the next posedge
    task automatic drive_start(input logic m, input logic [3:0] s, input logic [7:0] nw);
        mode = m; seed = s; num_words = nw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_job(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL job_timeout: got %0d pending events busy=%0b, expected 0 and idle", exp_q.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load"},   32'(lfsr_load_seed), 32'd0);
        chk({tag, "_seed"},   32'(lfsr_seed_data), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_data"},   32'(out_data), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_err"},    32'(err), 32'd0);
        chk({tag, "_period"}, 32'(period), 32'd0);
    endtask

    initial begin
        int k;
        int lc0;
        logic [3:0] gen5 [5];
        gen5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};

        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // PERIOD from seed 0001: period 15, done 18 cycles after the start edge
        @(negedge clk); k = cyc + 1;
        push_done(1'b0, 5'd15, k + 17);
        drive_start(1'b1, 4'b0001, 8'd0);
        wait_job(40);
        chk("period_hold", 32'(period), 32'd15);

        // GEN five words from seed 0001
        @(negedge clk); k = cyc + 1;
        for (int i = 0; i < 5; i++) push_word(gen5[i], k + 1 + i);
        push_done(1'b0, 5'd0, k + 6);
        drive_start(1'b0, 4'b0001, 8'd5);
        wait_job(40);

        // zero seed: done with err on the cycle after start, no LOAD
        lc0 = load_cnt;
        @(negedge clk); k = cyc + 1;
        push_done(1'b1, 5'd0, k);
        drive_start(1'b1, 4'b0000, 8'd0);
        wait_job(10);
        chk("zero_noload", load_cnt, lc0);
        chk("zero_err_sticky", 32'(err), 32'd1);

        // next accepted start clears err
        @(negedge clk); k = cyc + 1;
        push_word(4'b0001, k + 1);
        push_done(1'b0, 5'd0, k + 2);
        drive_start(1'b0, 4'b0001, 8'd1);
        chk("err_cleared", 32'(err), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_job(10);

        // PERIOD on seed 1000 with stray zero-seed starts during RUN and DONE
        @(negedge clk); k = cyc + 1;
        push_done(1'b0, 5'd15, k + 17);
        drive_start(1'b1, 4'b1000, 8'd0);
        while (cyc < k + 5) @(negedge clk);
        drive_start(1'b0, 4'b0000, 8'd0);
        while (cyc < k + 17) @(negedge clk);
        drive_start(1'b0, 4'b0000, 8'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        wait_job(10);
        chk("stray_err", 32'(err), 32'd0);
        chk("stray_period", 32'(period), 32'd15);

        // GEN with zero words: done next cycle, no LOAD, no words
        lc0 = load_cnt;
        @(negedge clk); k = cyc + 1;
        push_done(1'b0, 5'd0, k);
        drive_start(1'b0, 4'b0101, 8'd0);
        wait_job(10);
        chk("nw0_noload", load_cnt, lc0);

        // abort on the third RUN cycle of a 10-word GEN job
        @(negedge clk); k = cyc + 1;
        push_word(4'b0001, k + 1);
        push_word(4'b0010, k + 2);
        push_word(4'b0100, k + 3);
        drive_start(1'b0, 4'b0001, 8'd10);
        while (cyc < k + 3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        wait_job(10);

        // PERIOD timeout with lfsr_data stuck at a value that never matches
        force_val = 4'b0101;
        force_en = 1'b1;
        @(negedge clk); k = cyc + 1;
        push_done(1'b1, 5'd0, k + 18);
        drive_start(1'b1, 4'b0001, 8'd0);
        wait_job(40);
        force_en = 1'b0;

        // reset during RUN
        @(negedge clk); k = cyc + 1;
        push_word(4'b0001, k + 1);
        push_word(4'b0010, k + 2);
        drive_start(1'b0, 4'b0001, 8'd10);
        while (cyc < k + 2) @(negedge clk);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        chk("midrst_queue", exp_q.size(), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        @(negedge clk); k = cyc + 1;
        push_done(1'b0, 5'd15, k + 17);
        drive_start(1'b1, 4'b1000, 8'd0);
        wait_job(40);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencing controller for the `lfsr` block. It loads a seed into the LFSR through its `load_seed`/`seed_data` port and then runs one of two jobs. GEN streams a fixed number of consecutive LFSR words to a consumer. PERIOD measures the cycle length of the sequence starting at that seed. It sits between a host/test master (start, seed, mode) and a free-running `lfsr` instance of the same `N`.

## Interface
- `N`, 4: LFSR width; must match the attached `lfsr`.
- `W`, 8: width of the word-count request.
- `clk` input 1: clock; shared with the attached `lfsr`.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: job request; sampled only in IDLE.
- `mode` input 1: 0 = GEN, 1 = PERIOD; captured with `start`.
- `seed` input N: seed value; captured with `start`.
- `num_words` input W: GEN word count; captured with `start`.
- `abort` input 1: cancels the job in LOAD or RUN.
- `lfsr_data` input N: current register value of the attached `lfsr`.
- `lfsr_load_seed` output 1: drives `lfsr.load_seed`.
- `lfsr_seed_data` output N: drives `lfsr.seed_data`.
- `busy` output 1: high in LOAD, RUN and DONE.
- `out_valid` output 1: GEN word strobe. There is no backpressure.
- `out_data` output N: GEN word, equal to `lfsr_data` while `out_valid` is high.
- `done` output 1: one-cycle pulse at job completion.
- `err` output 1: error flag; sticky until the next accepted `start`.
- `period` output N+1: measured period; held until the next accepted `start`.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- IDLE: `start`=1 captures `mode`, `seed`, `num_words` into registers `seed_q`, `mode_q`, `nw_q`. It also clears `err` and `period` and the counter `cnt` (width max(N+1,W)).
  - `seed`==0 (LFSR lockup state): set `err`=1 and go to DONE. LOAD is never entered.
  - `mode`=0 with `num_words`==0: go to DONE, `err`=0, no words emitted.
  - Otherwise: go to LOAD.
- LOAD (exactly one cycle): `lfsr_load_seed`=1, `lfsr_seed_data`=`seed_q`. Then go to RUN.
  - Outside LOAD, `lfsr_load_seed`=0. `lfsr_seed_data` holds `seed_q` at all times; its value outside LOAD is don't-care.
- RUN: `cnt` starts at 0 and increments by 1 each RUN cycle. On the first RUN cycle, `lfsr_data`==`seed_q`.
  - GEN: `out_valid`=1 and `out_data`=`lfsr_data` on every RUN cycle. When `cnt`==`nw_q`-1, go to DONE. Exactly `nw_q` words are emitted, the first equal to the seed.
  - PERIOD: if `cnt`!=0 and `lfsr_data`==`seed_q`, set `period`=`cnt` and go to DONE.
  - PERIOD timeout: if `cnt`==2^N with no match, set `err`=1, set `period`=0, and go to DONE.
- DONE (one cycle): `done`=1, `busy`=1. Then go to IDLE.
- `abort` in LOAD or RUN: go to IDLE on the next edge. `done` is not pulsed, `err` is unchanged, `out_valid` drops with the state change.
  - `abort` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored. It is not queued.
- Same-cycle `abort` and RUN termination: `abort` wins.
- `out_valid`=0 in every state other than RUN in GEN mode.

## Timing
- Reset (asynchronous, low): state IDLE; `lfsr_load_seed`=0, `lfsr_seed_data`=0, `busy`=0, `out_valid`=0, `out_data`=0, `done`=0, `err`=0, `period`=0; all capture registers and `cnt` = 0.
- Reset asserted mid-job: the same values apply immediately. No `done` pulse is issued.
- Edge k samples `start`. LOAD occupies cycle k+1. RUN begins at cycle k+2 with `lfsr_data`=seed.
- GEN: words appear on cycles k+2 .. k+1+`num_words`. `done` pulses at cycle k+2+`num_words`.
- PERIOD: for period P, the match occurs at RUN cycle `cnt`=P and `done` pulses P+3 cycles after the start edge. Timeout: `done` pulses at k+3+2^N.
- Zero-seed error: `done` and `err` are both high at cycle k+1.
- `busy` and `done` are registered state decodes, glitch-free.
- `out_data` is combinational from `lfsr_data` with no added latency.

## Test plan
- N=4 (`lfsr` taps 1100), PERIOD, seed 0001 -> `done` pulses 18 cycles after the start edge, `period`=15, `err`=0.
- N=4, GEN, seed 0001, `num_words`=5 -> `out_valid` high 5 cycles with words 0001, 0010, 0100, 1001, 0011, then one `done` pulse.
- PERIOD with seed 0000 -> `done`=1 and `err`=1 on the cycle after start, `lfsr_load_seed` never asserted, `period`=0. The next valid `start` clears `err`.
- GEN, `num_words`=0 -> `done` after one cycle, no `out_valid`, no LOAD. `start` pulsed during `busy` -> ignored, and `period`/`err` are not cleared.
- `abort` on RUN cycle 3 of a GEN job with `num_words`=10 -> exactly 3 words emitted, IDLE next cycle, no `done`.
- Reset pulled low during RUN -> all outputs at reset values immediately. After release, a new PERIOD job on seed 1000 -> `period`=15.
